// File: rtl/pic_pkg.sv
// Shared types and PIC command-word encodings for the 8259 init sequencer.
// Every ICW/OCW bit layout lives here so the FSMs only deal in word indices.
package pic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_INIT,
        ST_READY,
        ST_CMD
    } top_state_e;

    typedef enum logic [2:0] {
        WC_IDLE,
        WC_SETUP,
        WC_STROBE,
        WC_HOLD,
        WC_RECOVER
    } wc_state_e;

    typedef enum logic [2:0] {
        W_ICW1,
        W_ICW2,
        W_ICW3,
        W_ICW4,
        W_OCW1
    } word_e;

    localparam logic [7:0] ICW1_FIXED     = 8'h10;
    localparam int         ICW1_LTIM_BIT  = 3;
    localparam int         ICW1_SNGL_BIT  = 1;
    localparam int         ICW1_IC4_BIT   = 0;
    localparam logic [7:0] ICW4_FIXED     = 8'h01;
    localparam int         ICW4_AEOI_BIT  = 1;
    localparam int         OCW_SEL_LSB    = 3;
    localparam int         OCW3_RSVD_BIT  = 7;
    localparam logic [1:0] OCW2_SEL       = 2'b00;
    localparam logic [1:0] OCW3_SEL       = 2'b01;

    typedef struct packed {
        logic       ltim;
        logic       sngl;
        logic       ic4;
        logic [4:0] vector_base;
        logic [7:0] icw3;
        logic       aeoi;
        logic [7:0] mask;
    } pic_cfg_t;

    // Disabled words are skipped: ICW3 only in cascade mode, ICW4 only when requested.
    function automatic word_e next_word(word_e w, logic sngl, logic ic4);
        word_e n;
        case (w)
            W_ICW1:  n = W_ICW2;
            W_ICW2:  n = !sngl ? W_ICW3 : (ic4 ? W_ICW4 : W_OCW1);
            W_ICW3:  n = ic4 ? W_ICW4 : W_OCW1;
            default: n = W_OCW1;
        endcase
        return n;
    endfunction

    function automatic logic word_a0(word_e w);
        return (w != W_ICW1);
    endfunction

    function automatic logic [7:0] word_data(word_e w, pic_cfg_t c);
        logic [7:0] v;
        v = 8'h00;
        case (w)
            W_ICW1: begin
                v                = ICW1_FIXED;
                v[ICW1_LTIM_BIT] = c.ltim;
                v[ICW1_SNGL_BIT] = c.sngl;
                v[ICW1_IC4_BIT]  = c.ic4;
            end
            W_ICW2:  v = {c.vector_base, 3'b000};
            W_ICW3:  v = c.icw3;
            W_ICW4: begin
                v                = ICW4_FIXED;
                v[ICW4_AEOI_BIT] = c.aeoi;
            end
            default: v = c.mask;
        endcase
        return v;
    endfunction

    function automatic logic [7:0] ocw_encode(logic sel, logic [7:0] data);
        logic [7:0] v;
        v = data;
        v[OCW_SEL_LSB +: 2] = sel ? OCW3_SEL : OCW2_SEL;
        if (sel) begin
            v[OCW3_RSVD_BIT] = 1'b0;
        end
        return v;
    endfunction

endpackage

// File: rtl/pic_bus_write_cycle.sv
// One PIC write: SETUP, STROBE, HOLD, RECOVER with all bus pins registered.
// A new go is taken in RECOVER, so consecutive words run back-to-back.
module pic_bus_write_cycle
    import pic_pkg::*;
#(
    parameter int SETUP_CYCLES  = 1,
    parameter int WR_LOW_CYCLES = 2,
    parameter int HOLD_CYCLES   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       go,
    input  logic       addr,
    input  logic [7:0] data,
    output logic       cs_n,
    output logic       wr_n,
    output logic       a0,
    output logic [7:0] d_out,
    output logic       d_oe,
    output logic       last
);

    localparam int MAX_CYCLES =
        (SETUP_CYCLES > WR_LOW_CYCLES)
            ? ((SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES)
            : ((WR_LOW_CYCLES > HOLD_CYCLES) ? WR_LOW_CYCLES : HOLD_CYCLES);
    localparam int CW = $clog2(MAX_CYCLES + 1);

    localparam logic [CW-1:0] SETUP_INIT  = CW'(SETUP_CYCLES - 1);
    localparam logic [CW-1:0] WR_LOW_INIT = CW'(WR_LOW_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_INIT   = CW'(HOLD_CYCLES - 1);

    wc_state_e     phase_q, phase_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          cs_n_q, cs_n_d;
    logic          wr_n_q, wr_n_d;
    logic          a0_q, a0_d;
    logic [7:0]    d_q, d_d;
    logic          d_oe_q, d_oe_d;

    always_comb begin
        phase_d = phase_q;
        cnt_d   = cnt_q;
        cs_n_d  = cs_n_q;
        wr_n_d  = wr_n_q;
        a0_d    = a0_q;
        d_d     = d_q;
        d_oe_d  = d_oe_q;
        case (phase_q)
            WC_SETUP: begin
                if (cnt_q == '0) begin
                    phase_d = WC_STROBE;
                    cnt_d   = WR_LOW_INIT;
                    wr_n_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            WC_STROBE: begin
                if (cnt_q == '0) begin
                    phase_d = WC_HOLD;
                    cnt_d   = HOLD_INIT;
                    wr_n_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            WC_HOLD: begin
                if (cnt_q == '0) begin
                    phase_d = WC_RECOVER;
                    cs_n_d  = 1'b1;
                    d_oe_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                phase_d = WC_IDLE;
                if (go) begin
                    phase_d = WC_SETUP;
                    cnt_d   = SETUP_INIT;
                    cs_n_d  = 1'b0;
                    d_oe_d  = 1'b1;
                    a0_d    = addr;
                    d_d     = data;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= WC_IDLE;
            cnt_q   <= '0;
            cs_n_q  <= 1'b1;
            wr_n_q  <= 1'b1;
            a0_q    <= 1'b0;
            d_q     <= 8'h00;
            d_oe_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            cs_n_q  <= cs_n_d;
            wr_n_q  <= wr_n_d;
            a0_q    <= a0_d;
            d_q     <= d_d;
            d_oe_q  <= d_oe_d;
        end
    end

    assign cs_n  = cs_n_q;
    assign wr_n  = wr_n_q;
    assign a0    = a0_q;
    assign d_out = d_q;
    assign d_oe  = d_oe_q;
    assign last  = (phase_q == WC_RECOVER);

endmodule

// File: rtl/pic_init_sequencer.sv
// Programs an 8259 PIC (ICW1..ICW4, OCW1) after start, then arbitrates
// runtime OCW2/OCW3 requests onto the same exclusively owned write port.
module pic_init_sequencer
    import pic_pkg::*;
#(
    parameter int SETUP_CYCLES  = 1,
    parameter int WR_LOW_CYCLES = 2,
    parameter int HOLD_CYCLES   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       cfg_ltim,
    input  logic       cfg_sngl,
    input  logic       cfg_ic4,
    input  logic [4:0] cfg_vector_base,
    input  logic [7:0] cfg_icw3,
    input  logic       cfg_aeoi,
    input  logic [7:0] cfg_mask,
    input  logic       ocw_req,
    input  logic       ocw_sel,
    input  logic [7:0] ocw_data,
    output logic       ocw_ack,
    output logic       cs_n,
    output logic       wr_n,
    output logic       rd_n,
    output logic       a0,
    output logic [7:0] d_out,
    output logic       d_oe,
    output logic       busy,
    output logic       done,
    output logic       initialized
);

    top_state_e state_q, state_d;
    word_e      word_q, word_d;
    pic_cfg_t   cfg_q, cfg_d, cfg_in;
    logic       done_q, done_d;
    logic       ack_q, ack_d;
    logic       init_q, init_d;
    logic       busy_q, busy_d;
    logic       go, go_a0, wc_last;
    logic [7:0] go_data;

    assign cfg_in = {cfg_ltim, cfg_sngl, cfg_ic4, cfg_vector_base,
                     cfg_icw3, cfg_aeoi, cfg_mask};

    // start has priority over a pending OCW request in READY.
    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        cfg_d   = cfg_q;
        done_d  = 1'b0;
        ack_d   = 1'b0;
        init_d  = init_q;
        go      = 1'b0;
        go_a0   = 1'b0;
        go_data = 8'h00;
        case (state_q)
            ST_IDLE, ST_READY: begin
                if (start) begin
                    state_d = ST_INIT;
                    word_d  = W_ICW1;
                    cfg_d   = cfg_in;
                    init_d  = 1'b0;
                    go      = 1'b1;
                    go_a0   = word_a0(W_ICW1);
                    go_data = word_data(W_ICW1, cfg_in);
                end else if (state_q == ST_READY && ocw_req) begin
                    state_d = ST_CMD;
                    ack_d   = 1'b1;
                    go      = 1'b1;
                    go_a0   = 1'b0;
                    go_data = ocw_encode(ocw_sel, ocw_data);
                end
            end
            ST_INIT: begin
                if (wc_last) begin
                    if (word_q == W_OCW1) begin
                        state_d = ST_READY;
                        done_d  = 1'b1;
                        init_d  = 1'b1;
                    end else begin
                        word_d  = next_word(word_q, cfg_q.sngl, cfg_q.ic4);
                        go      = 1'b1;
                        go_a0   = word_a0(word_d);
                        go_data = word_data(word_d, cfg_q);
                    end
                end
            end
            ST_CMD: begin
                if (wc_last) begin
                    state_d = ST_READY;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d == ST_INIT) || (state_d == ST_CMD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            word_q  <= W_ICW1;
            cfg_q   <= '0;
            done_q  <= 1'b0;
            ack_q   <= 1'b0;
            init_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            cfg_q   <= cfg_d;
            done_q  <= done_d;
            ack_q   <= ack_d;
            init_q  <= init_d;
            busy_q  <= busy_d;
        end
    end

    pic_bus_write_cycle #(
        .SETUP_CYCLES  (SETUP_CYCLES),
        .WR_LOW_CYCLES (WR_LOW_CYCLES),
        .HOLD_CYCLES   (HOLD_CYCLES)
    ) u_write (
        .clk   (clk),
        .rst   (rst),
        .go    (go),
        .addr  (go_a0),
        .data  (go_data),
        .cs_n  (cs_n),
        .wr_n  (wr_n),
        .a0    (a0),
        .d_out (d_out),
        .d_oe  (d_oe),
        .last  (wc_last)
    );

    assign rd_n        = 1'b1;
    assign ocw_ack     = ack_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign initialized = init_q;

endmodule

// File: tb/tb_pic_init_sequencer.sv
// Directed bench for pic_init_sequencer: a passive bus monitor logs every
// PIC write, and each scenario task compares the log against hand-computed words.
module tb_pic_init_sequencer;

    logic       clk = 1'b0;
    logic       rst, start;
    logic       cfg_ltim, cfg_sngl, cfg_ic4, cfg_aeoi;
    logic [4:0] cfg_vector_base;
    logic [7:0] cfg_icw3, cfg_mask;
    logic       ocw_req, ocw_sel;
    logic [7:0] ocw_data;
    logic       ocw_ack, cs_n, wr_n, rd_n, a0, d_oe, busy, done, initialized;
    logic [7:0] d_out;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [8:0] wlog[$];
    int         wrlog[$];
    int         cslog[$];
    int         done_cnt = 0, ack_cnt = 0, done_cyc = -1, ack_cyc = -1, bad_bus = 0;
    int         wr_len = 0, cs_len = 0;
    logic       cs_prev = 1'b1;
    logic [8:0] cap = '0;
    logic [8:0] exp_words [5];

    pic_init_sequencer dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .cfg_ltim        (cfg_ltim),
        .cfg_sngl        (cfg_sngl),
        .cfg_ic4         (cfg_ic4),
        .cfg_vector_base (cfg_vector_base),
        .cfg_icw3        (cfg_icw3),
        .cfg_aeoi        (cfg_aeoi),
        .cfg_mask        (cfg_mask),
        .ocw_req         (ocw_req),
        .ocw_sel         (ocw_sel),
        .ocw_data        (ocw_data),
        .ocw_ack         (ocw_ack),
        .cs_n            (cs_n),
        .wr_n            (wr_n),
        .rd_n            (rd_n),
        .a0              (a0),
        .d_out           (d_out),
        .d_oe            (d_oe),
        .busy            (busy),
        .done            (done),
        .initialized     (initialized)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Passive monitor, sampled mid-cycle: logs completed writes and protocol slips.
    always @(negedge clk) begin
        if (rst) begin
            wr_len  = 0;
            cs_len  = 0;
            cs_prev = 1'b1;
        end else begin
            if (d_oe !== !cs_n) bad_bus++;
            if (rd_n !== 1'b1) bad_bus++;
            if (!cs_n) begin
                if (!cs_prev && ({a0, d_out} !== cap)) bad_bus++;
                cap = {a0, d_out};
                cs_len++;
            end
            if (!wr_n) begin
                wr_len++;
                if (cs_n) bad_bus++;
            end
            if (cs_n && !cs_prev) begin
                wlog.push_back(cap);
                wrlog.push_back(wr_len);
                cslog.push_back(cs_len);
                wr_len = 0;
                cs_len = 0;
            end
            cs_prev = cs_n;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (ocw_ack) begin
                ack_cnt++;
                ack_cyc = cyc;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_cfg(input logic ltim, input logic sngl, input logic ic4,
                           input logic [4:0] vb, input logic [7:0] icw3,
                           input logic aeoi, input logic [7:0] mask);
        cfg_ltim        = ltim;
        cfg_sngl        = sngl;
        cfg_ic4         = ic4;
        cfg_vector_base = vb;
        cfg_icw3        = icw3;
        cfg_aeoi        = aeoi;
        cfg_mask        = mask;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(3);
        checks++;
        if ({cs_n, wr_n, rd_n, a0, d_oe, ocw_ack, busy, done, initialized} !== 9'b111000000)
            $display("[TB] FAIL reset_strobes: got %b expected %b",
                     {cs_n, wr_n, rd_n, a0, d_oe, ocw_ack, busy, done, initialized}, 9'b111000000);
        checks++;
        if (d_out !== 8'h00) $display("[TB] FAIL reset_dout: got %h expected 00", d_out);
        if (d_out !== 8'h00 || {cs_n, wr_n, rd_n, a0, d_oe, ocw_ack, busy, done, initialized} !== 9'b111000000)
            failures += ((d_out !== 8'h00) ? 1 : 0) +
                        (({cs_n, wr_n, rd_n, a0, d_oe, ocw_ack, busy, done, initialized} !== 9'b111000000) ? 1 : 0);
        rst = 1'b0;
        tick(3);
        checks++;
        if (busy !== 1'b0 || cs_n !== 1'b1) begin
            failures++;
            $display("[TB] FAIL idle_quiet: got busy=%b cs_n=%b expected busy=0 cs_n=1", busy, cs_n);
        end
    endtask

    // Runs one init sequence against exp_words; poke_start retries start mid-sequence.
    task automatic test_init(input string name, input logic ltim, input logic sngl,
                             input logic ic4, input logic [4:0] vb, input logic [7:0] icw3,
                             input logic aeoi, input logic [7:0] mask,
                             input int nwords, input bit poke_start);
        int ts, d0, k0, w0;
        d0 = done_cnt;
        k0 = ack_cnt;
        w0 = wlog.size();
        set_cfg(ltim, sngl, ic4, vb, icw3, aeoi, mask);
        start = 1'b1;
        ts    = cyc;
        tick(1);
        start = 1'b0;
        set_cfg(~ltim, ~sngl, ~ic4, ~vb, ~icw3, ~aeoi, ~mask);
        checks++;
        if (busy !== 1'b1 || cs_n !== 1'b0 || initialized !== 1'b0 || {a0, d_out} !== exp_words[0]) begin
            failures++;
            $display("[TB] FAIL %s_first_setup: got busy=%b cs_n=%b init=%b word=%h expected 1 0 0 %h",
                     name, busy, cs_n, initialized, {a0, d_out}, exp_words[0]);
        end
        if (poke_start) begin
            tick(6);
            start = 1'b1;
            tick(1);
            start = 1'b0;
        end
        for (int i = 0; i < 200 && done_cnt == d0; i++) tick(1);
        checks++;
        if (done_cnt != d0 + 1) begin
            failures++;
            $display("[TB] FAIL %s_done_count: got %0d expected %0d", name, done_cnt - d0, 1);
        end
        checks++;
        if (done_cyc != ts + 1 + 5 * nwords) begin
            failures++;
            $display("[TB] FAIL %s_done_cycle: got %0d expected %0d", name, done_cyc - ts, 1 + 5 * nwords);
        end
        checks++;
        if (wlog.size() - w0 != nwords) begin
            failures++;
            $display("[TB] FAIL %s_write_count: got %0d expected %0d", name, wlog.size() - w0, nwords);
        end
        for (int i = 0; i < nwords; i++) begin
            if (w0 + i < wlog.size()) begin
                checks++;
                if (wlog[w0 + i] !== exp_words[i]) begin
                    failures++;
                    $display("[TB] FAIL %s_word%0d: got %h expected %h", name, i, wlog[w0 + i], exp_words[i]);
                end
                checks++;
                if (wrlog[w0 + i] != 2 || cslog[w0 + i] != 4) begin
                    failures++;
                    $display("[TB] FAIL %s_width%0d: got wr=%0d cs=%0d expected wr=2 cs=4",
                             name, i, wrlog[w0 + i], cslog[w0 + i]);
                end
            end
        end
        checks++;
        if (initialized !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || ack_cnt != k0) begin
            failures++;
            $display("[TB] FAIL %s_ready: got init=%b busy=%b done=%b acks=%0d expected 1 0 0 0",
                     name, initialized, busy, done, ack_cnt - k0);
        end
    endtask

    task automatic test_ocw();
        logic       sel  [2] = '{1'b0, 1'b1};
        logic [7:0] data [2] = '{8'h20, 8'hFF};
        logic [8:0] expw [2] = '{9'h020, 9'h06F};
        int w0, k0;
        for (int k = 0; k < 2; k++) begin
            w0       = wlog.size();
            k0       = ack_cnt;
            ocw_sel  = sel[k];
            ocw_data = data[k];
            ocw_req  = 1'b1;
            tick(1);
            checks++;
            if (ocw_ack !== 1'b1 || busy !== 1'b1 || cs_n !== 1'b0) begin
                failures++;
                $display("[TB] FAIL ocw%0d_ack: got ack=%b busy=%b cs_n=%b expected 1 1 0",
                         k, ocw_ack, busy, cs_n);
            end
            ocw_req  = 1'b0;
            ocw_data = 8'h00;
            ocw_sel  = ~sel[k];
            for (int i = 0; i < 50 && wlog.size() == w0; i++) tick(1);
            checks++;
            if (wlog.size() != w0 + 1 || wlog[w0] !== expw[k]) begin
                failures++;
                $display("[TB] FAIL ocw%0d_write: got n=%0d word=%h expected n=1 word=%h",
                         k, wlog.size() - w0, (wlog.size() > w0) ? wlog[w0] : 9'h000, expw[k]);
            end
            checks++;
            if (ack_cnt != k0 + 1 || busy !== 1'b0 || initialized !== 1'b1) begin
                failures++;
                $display("[TB] FAIL ocw%0d_after: got acks=%0d busy=%b init=%b expected 1 0 1",
                         k, ack_cnt - k0, busy, initialized);
            end
        end
    endtask

    task automatic test_start_vs_req();
        int ts, w0, d0, k0;
        logic [8:0] expw [4] = '{9'h01A, 9'h188, 9'h133, 9'h063};
        w0 = wlog.size();
        d0 = done_cnt;
        k0 = ack_cnt;
        set_cfg(1'b1, 1'b1, 1'b0, 5'h11, 8'h00, 1'b0, 8'h33);
        ocw_sel  = 1'b0;
        ocw_data = 8'h7B;
        ocw_req  = 1'b1;
        start    = 1'b1;
        ts       = cyc;
        tick(1);
        start = 1'b0;
        checks++;
        if (ocw_ack !== 1'b0 || busy !== 1'b1 || initialized !== 1'b0) begin
            failures++;
            $display("[TB] FAIL race_start_wins: got ack=%b busy=%b init=%b expected 0 1 0",
                     ocw_ack, busy, initialized);
        end
        for (int i = 0; i < 100 && ack_cnt == k0; i++) tick(1);
        ocw_req = 1'b0;
        checks++;
        if (ack_cnt != k0 + 1 || done_cnt != d0 + 1 || done_cyc != ts + 16) begin
            failures++;
            $display("[TB] FAIL race_done: got acks=%0d dones=%0d done_at=%0d expected 1 1 16",
                     ack_cnt - k0, done_cnt - d0, done_cyc - ts);
        end
        checks++;
        if (ack_cyc != done_cyc + 1) begin
            failures++;
            $display("[TB] FAIL race_ack_timing: got ack-done=%0d expected 1", ack_cyc - done_cyc);
        end
        for (int i = 0; i < 50 && wlog.size() < w0 + 4; i++) tick(1);
        checks++;
        if (wlog.size() != w0 + 4) begin
            failures++;
            $display("[TB] FAIL race_write_count: got %0d expected 4", wlog.size() - w0);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (wlog[w0 + i] !== expw[i]) begin
                    failures++;
                    $display("[TB] FAIL race_word%0d: got %h expected %h", i, wlog[w0 + i], expw[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_write();
        int d0, k0;
        d0 = done_cnt;
        k0 = ack_cnt;
        set_cfg(1'b0, 1'b1, 1'b0, 5'h08, 8'h00, 1'b0, 8'hFB);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(6);
        checks++;
        if (wr_n !== 1'b0 || cs_n !== 1'b0 || {a0, d_out} !== 9'h140) begin
            failures++;
            $display("[TB] FAIL rst_pre_strobe: got wr_n=%b cs_n=%b word=%h expected 0 0 140",
                     wr_n, cs_n, {a0, d_out});
        end
        rst = 1'b1;
        tick(1);
        checks++;
        if ({wr_n, cs_n, d_oe, busy, done, initialized, ocw_ack} !== 7'b1100000) begin
            failures++;
            $display("[TB] FAIL rst_release: got %b expected 1100000",
                     {wr_n, cs_n, d_oe, busy, done, initialized, ocw_ack});
        end
        rst = 1'b0;
        tick(30);
        checks++;
        if (done_cnt != d0 || ack_cnt != k0 || busy !== 1'b0 || initialized !== 1'b0 || cs_n !== 1'b1) begin
            failures++;
            $display("[TB] FAIL rst_aftermath: got dones=%0d acks=%0d busy=%b init=%b cs_n=%b expected 0 0 0 0 1",
                     done_cnt - d0, ack_cnt - k0, busy, initialized, cs_n);
        end
    endtask

    task automatic test_req_pending();
        int ts, w0, d0, k0;
        logic [8:0] expw [5] = '{9'h013, 9'h120, 9'h101, 9'h1F0, 9'h00B};
        w0 = wlog.size();
        d0 = done_cnt;
        k0 = ack_cnt;
        ocw_sel  = 1'b1;
        ocw_data = 8'h93;
        ocw_req  = 1'b1;
        tick(4);
        checks++;
        if (ack_cnt != k0 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL pend_idle: got acks=%0d busy=%b expected 0 0", ack_cnt - k0, busy);
        end
        set_cfg(1'b0, 1'b1, 1'b1, 5'h04, 8'hAA, 1'b0, 8'hF0);
        start = 1'b1;
        ts    = cyc;
        tick(1);
        start = 1'b0;
        for (int i = 0; i < 100 && ack_cnt == k0; i++) tick(1);
        ocw_req = 1'b0;
        checks++;
        if (done_cnt != d0 + 1 || done_cyc != ts + 21 || ack_cnt != k0 + 1 || ack_cyc != done_cyc + 1) begin
            failures++;
            $display("[TB] FAIL pend_timing: got dones=%0d done_at=%0d acks=%0d ack-done=%0d expected 1 21 1 1",
                     done_cnt - d0, done_cyc - ts, ack_cnt - k0, ack_cyc - done_cyc);
        end
        for (int i = 0; i < 50 && wlog.size() < w0 + 5; i++) tick(1);
        checks++;
        if (wlog.size() != w0 + 5) begin
            failures++;
            $display("[TB] FAIL pend_write_count: got %0d expected 5", wlog.size() - w0);
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (wlog[w0 + i] !== expw[i]) begin
                    failures++;
                    $display("[TB] FAIL pend_word%0d: got %h expected %h", i, wlog[w0 + i], expw[i]);
                end
            end
        end
    endtask

    task automatic test_req_dropped();
        int w0, d0, k0;
        w0 = wlog.size();
        d0 = done_cnt;
        k0 = ack_cnt;
        set_cfg(1'b0, 1'b1, 1'b0, 5'h08, 8'h00, 1'b0, 8'hFB);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(2);
        ocw_sel  = 1'b0;
        ocw_data = 8'h20;
        ocw_req  = 1'b1;
        tick(3);
        ocw_req = 1'b0;
        for (int i = 0; i < 100 && done_cnt == d0; i++) tick(1);
        tick(8);
        checks++;
        if (ack_cnt != k0 || wlog.size() != w0 + 3 || done_cnt != d0 + 1 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL drop_no_write: got acks=%0d writes=%0d dones=%0d busy=%b expected 0 3 1 0",
                     ack_cnt - k0, wlog.size() - w0, done_cnt - d0, busy);
        end
    endtask

    task automatic test_bus_integrity();
        checks++;
        if (bad_bus != 0) begin
            failures++;
            $display("[TB] FAIL bus_integrity: got %0d protocol slips expected 0", bad_bus);
        end
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        ocw_req  = 1'b0;
        ocw_sel  = 1'b0;
        ocw_data = 8'h00;
        set_cfg(1'b0, 1'b0, 1'b0, 5'h00, 8'h00, 1'b0, 8'h00);

        test_reset();

        exp_words = '{9'h012, 9'h140, 9'h1FB, 9'h000, 9'h000};
        test_init("init3", 1'b0, 1'b1, 1'b0, 5'h08, 8'hAA, 1'b0, 8'hFB, 3, 1'b0);

        exp_words = '{9'h019, 9'h1F8, 9'h104, 9'h103, 9'h15A};
        test_init("init5", 1'b1, 1'b0, 1'b1, 5'h1F, 8'h04, 1'b1, 8'h5A, 5, 1'b0);

        exp_words = '{9'h010, 9'h150, 9'h180, 9'h100, 9'h000};
        test_init("init4_busy_start", 1'b0, 1'b0, 1'b0, 5'h0A, 8'h80, 1'b1, 8'h00, 4, 1'b1);

        test_ocw();
        test_start_vs_req();
        test_reset_mid_write();
        test_req_pending();
        test_req_dropped();
        test_bus_integrity();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
